ssp_rx_fifo_p: RTL and testbench

SSP_RX_FIFO_P -- requirements
Module: ssp_rx_fifo_p

---
 rtl/ssp_pkg.sv | 6 +
 rtl/ssp_rx_fifo_p_if.sv | 28 ++
 rtl/ssp_edge_det.sv | 20 ++
 rtl/ssp_rx_fifo_p.sv | 52 +++++
 tb/tb_ssp_rx_fifo_p.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ssp_pkg.sv
// ssp_pkg: default data width, depth and watermark shared by the SSP RX and TX FIFOs
package ssp_pkg;
    localparam int SSP_DATA_W = 8;
    localparam int SSP_DEPTH  = 4;
    localparam int SSP_RX_WM  = 2;
endpackage

// File: rtl/ssp_rx_fifo_p_if.sv
// ssp_rx_fifo_p_if: APB read side, receive strobe and status bundle of the SSP RX FIFO
interface ssp_rx_fifo_p_if
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_DEPTH
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic              PSEL;
    logic              PWRITE;
    logic [DATA_W-1:0] RxData;
    logic              rx_ready;
    logic              ROR_CLR;
    logic [DATA_W-1:0] PRDATA;
    logic              SSPRXINTR;
    logic              SSPRORINTR;
    logic              rx_full;
    logic              rx_empty;
    logic [LW-1:0]     rx_level;
    modport slave (
        input  PSEL, PWRITE, RxData, rx_ready, ROR_CLR,
        output PRDATA, SSPRXINTR, SSPRORINTR, rx_full, rx_empty, rx_level
    );
    modport master (
        output PSEL, PWRITE, RxData, rx_ready, ROR_CLR,
        input  PRDATA, SSPRXINTR, SSPRORINTR, rx_full, rx_empty, rx_level
    );
endinterface

// File: rtl/ssp_edge_det.sv
// ssp_edge_det: rising-edge pulse of a PCLK-synchronous level, shared by the SSP RX and TX FIFOs
module ssp_edge_det (
    input  logic PCLK,
    input  logic CLEAR,
    input  logic d,
    output logic rise
);
    logic prev, armed;
    // armed stays low after CLEAR until d has been seen low, so a level held across CLEAR is not an edge
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= d;
            armed <= armed | ~d;
        end
    end
    assign rise = d & ~prev & armed;
endmodule

// File: rtl/ssp_rx_fifo_p.sv
// ssp_rx_fifo_p: SSP receive FIFO filled on rx_ready rising edges and drained by APB reads
module ssp_rx_fifo_p
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_DEPTH,
    parameter int RX_WM  = SSP_RX_WM
) (
    input logic            PCLK,
    input logic            CLEAR,
    ssp_rx_fifo_p_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] prdata;
    logic              ror, wr_ev, rd_ev, do_wr, full, empty;
    ssp_edge_det u_edge (.PCLK(PCLK), .CLEAR(CLEAR), .d(bus.rx_ready), .rise(wr_ev));
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rd_ev = bus.PSEL & ~bus.PWRITE & ~empty;
    assign do_wr = wr_ev & ~full;
    always_ff @(posedge PCLK) begin
        if (do_wr && !CLEAR) mem[wr_ptr] <= bus.RxData;
    end
    // a write while full is dropped even if a read frees a slot in the same cycle
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            prdata <= '0;
            ror    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ev) begin
                prdata <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_wr & ~rd_ev) - CW'(rd_ev & ~do_wr);
            ror   <= (wr_ev & full) | (ror & ~bus.ROR_CLR);
        end
    end
    assign bus.PRDATA     = prdata;
    assign bus.SSPRORINTR = ror;
    assign bus.SSPRXINTR  = count >= CW'(RX_WM);
    assign bus.rx_full    = full;
    assign bus.rx_empty   = empty;
    assign bus.rx_level   = count;
endmodule

// File: tb/tb_ssp_rx_fifo_p.sv
// tb_ssp_rx_fifo_p: directed stimulus with a read-data scoreboard for ssp_rx_fifo_p (DATA_W=8, DEPTH=4, RX_WM=2)
module tb_ssp_rx_fifo_p;
    logic PCLK = 1'b0;
    logic CLEAR;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    ssp_rx_fifo_p_if bus ();
    ssp_rx_fifo_p dut (.PCLK(PCLK), .CLEAR(CLEAR), .bus(bus));
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // each accepted read is compared against the oldest expected word one edge later
    always @(posedge PCLK) begin
        if (!CLEAR && bus.PSEL && !bus.PWRITE && !bus.rx_empty) begin
            #1;
            if (exp_q.size() == 0) check("rd_unexpected", bus.PRDATA, 32'hFFFF_FFFF);
            else check("prdata", bus.PRDATA, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.RxData = d;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    task automatic rd();
        bus.PSEL = 1'b1;
        bus.PWRITE = 1'b0;
        tick();
        bus.PSEL = 1'b0;
    endtask

    task automatic wr_rd(input logic [7:0] d);
        bus.RxData = d;
        bus.rx_ready = 1'b1;
        bus.PSEL = 1'b1;
        bus.PWRITE = 1'b0;
        tick();
        bus.rx_ready = 1'b0;
        bus.PSEL = 1'b0;
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, bus.rx_empty, 1);
        check({tag, "_full"}, bus.rx_full, 0);
        check({tag, "_rxintr"}, bus.SSPRXINTR, 0);
        check({tag, "_ror"}, bus.SSPRORINTR, 0);
        check({tag, "_level"}, bus.rx_level, 0);
        check({tag, "_prdata"}, bus.PRDATA, 0);
    endtask

    initial begin
        CLEAR = 1'b1;
        bus.PSEL = 1'b0;
        bus.PWRITE = 1'b0;
        bus.RxData = '0;
        bus.rx_ready = 1'b0;
        bus.ROR_CLR = 1'b0;
        tick();
        tick();
        CLEAR = 1'b0;
        tick();
        check_reset("reset");

        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        wr(8'hA1);
        check("wm_below_intr", bus.SSPRXINTR, 0);
        wr(8'hB2);
        check("two_level", bus.rx_level, 2);
        check("two_intr", bus.SSPRXINTR, 1);
        rd();
        rd();
        check("two_empty", bus.rx_empty, 1);
        check("two_intr_off", bus.SSPRXINTR, 0);

        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            wr(8'(i));
            if (i == 4) check("fill_ror_before", bus.SSPRORINTR, 0);
        end
        check("fill_full", bus.rx_full, 1);
        check("fill_level", bus.rx_level, 4);
        check("fill_ror", bus.SSPRORINTR, 1);
        repeat (4) rd();
        check("drain_empty", bus.rx_empty, 1);
        rd();
        check("empty_rd_hold", bus.PRDATA, 8'h04);
        check("empty_rd_level", bus.rx_level, 0);
        check("ror_sticky", bus.SSPRORINTR, 1);
        bus.ROR_CLR = 1'b1;
        tick();
        bus.ROR_CLR = 1'b0;
        check("ror_clr", bus.SSPRORINTR, 0);

        bus.RxData = 8'h3C;
        bus.rx_ready = 1'b1;
        repeat (10) tick();
        bus.rx_ready = 1'b0;
        tick();
        check("held_level", bus.rx_level, 1);
        exp_q.push_back(8'h3C);
        rd();
        check("held_drained", bus.rx_level, 0);

        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h41 + 8'(i));
            wr(8'h41 + 8'(i));
        end
        wr_rd(8'h99);
        check("full_wr_rd_level", bus.rx_level, 3);
        check("full_wr_rd_ror", bus.SSPRORINTR, 1);
        exp_q.push_back(8'h45);
        wr(8'h45);
        check("refill_full", bus.rx_full, 1);
        bus.ROR_CLR = 1'b1;
        bus.RxData = 8'h66;
        bus.rx_ready = 1'b1;
        tick();
        bus.ROR_CLR = 1'b0;
        bus.rx_ready = 1'b0;
        check("ror_set_wins", bus.SSPRORINTR, 1);
        tick();
        bus.ROR_CLR = 1'b1;
        tick();
        bus.ROR_CLR = 1'b0;
        check("ror_clr2", bus.SSPRORINTR, 0);
        repeat (4) rd();
        check("ovr_drained", bus.rx_empty, 1);

        exp_q.push_back(8'h10);
        wr(8'h10);
        for (int i = 1; i < 12; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            wr_rd(8'h10 + 8'(i));
            check("pair_level", bus.rx_level, 1);
        end
        rd();
        check("pairs_end_level", bus.rx_level, 0);
        check("pairs_last", bus.PRDATA, 8'h1B);

        wr_rd(8'h77);
        check("empty_wr_rd_level", bus.rx_level, 1);
        check("empty_wr_rd_hold", bus.PRDATA, 8'h1B);
        exp_q.push_back(8'h77);
        rd();

        wr(8'h51);
        wr(8'h52);
        wr(8'h53);
        check("pre_clear_level", bus.rx_level, 3);
        bus.rx_ready = 1'b1;
        bus.RxData = 8'h5F;
        CLEAR = 1'b1;
        tick();
        check_reset("clear");
        CLEAR = 1'b0;
        repeat (3) tick();
        check("clear_held_level", bus.rx_level, 0);
        bus.rx_ready = 1'b0;
        tick();
        bus.RxData = 8'h5A;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
        check("clear_retoggle_level", bus.rx_level, 1);
        exp_q.push_back(8'h5A);
        rd();
        tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
